// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and constants for the pipeline sequencer
//
// Holds the sequencer state enum, default MDU latencies, the per-stage
// enable/flush struct and the helper that applies hazard/branch priority.

package pipe_pkg;

    localparam int MUL_CYCLES_DEF = 4;
    localparam int DIV_CYCLES_DEF = 32;
    localparam int CNT_W_DEF      = 6;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MD_WAIT = 2'd1,
        MD_DONE = 2'd2
    } pipe_state_t;

    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic if_id_flush;
        logic id_exe_en;
        logic id_exe_flush;
        logic exe_mem_flush;
    } stage_ctrl_t;

    // Front end frozen, EXE/MEM fed bubbles while the MDU owns EXE.
    localparam stage_ctrl_t CTRL_MD_HOLD = '{
        pc_en: 1'b0, if_id_en: 1'b0, if_id_flush: 1'b0,
        id_exe_en: 1'b0, id_exe_flush: 1'b0, exe_mem_flush: 1'b1
    };

    // Hazard beats branch: the ID instruction is held and its branch is
    // re-evaluated next cycle, so a taken branch must not flush IF/ID now.
    function automatic stage_ctrl_t ctrl_service(input logic hazard, input logic branch);
        stage_ctrl_t c;
        c = '{
            pc_en: 1'b1, if_id_en: 1'b1, if_id_flush: 1'b0,
            id_exe_en: 1'b1, id_exe_flush: 1'b0, exe_mem_flush: 1'b0
        };
        if (hazard) begin
            c.pc_en        = 1'b0;
            c.if_id_en     = 1'b0;
            c.id_exe_flush = 1'b1;
        end else if (branch) begin
            c.if_id_flush  = 1'b1;
        end
        return c;
    endfunction

endpackage

// File: rtl/md_latency_cnt.sv
// rtl/md_latency_cnt.sv - loadable down-counter with zero detect for MDU latency
//
// Ports:
//   clk, rst   : clock, asynchronous active-high reset (count cleared to 0)
//   load       : load load_val (has priority over dec)
//   load_val   : value to load
//   dec        : decrement by one; ignored at zero so the count never wraps
//   zero       : count is zero

module md_latency_cnt #(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - 5-stage pipeline sequencer: stalls, flushes, MDU hold
//
// Optional build macro: PIPE_CTRL_PERF_EN (adds 32-bit saturating perf counters).
//
// Ports:
//   clk, rst       : clock, asynchronous active-high reset
//   hazard_stall   : data-hazard stall request for the ID instruction
//   branch_taken   : jump/branch resolved taken in ID
//   md_req         : EXE instruction is a mult/div
//   md_is_div      : qualifies md_req (1 = divide)
//   pc_en, if_id_en, id_exe_en            : stage register enables
//   if_id_flush, id_exe_flush, exe_mem_flush : stage bubble loads
//   md_busy        : MDU operation in progress
//   md_done        : one-cycle pulse on the MDU completion cycle
//   perf_haz_cnt, perf_md_cnt, perf_flush_cnt : (PIPE_CTRL_PERF_EN only)

module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int MUL_CYCLES = MUL_CYCLES_DEF,
    parameter int DIV_CYCLES = DIV_CYCLES_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hazard_stall,
    input  logic        branch_taken,
    input  logic        md_req,
    input  logic        md_is_div,
    output logic        pc_en,
    output logic        if_id_en,
    output logic        if_id_flush,
    output logic        id_exe_en,
    output logic        id_exe_flush,
    output logic        exe_mem_flush,
    output logic        md_busy,
    output logic        md_done
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0] perf_haz_cnt,
    output logic [31:0] perf_md_cnt,
    output logic [31:0] perf_flush_cnt
`endif
);

    // The request cycle (RUN) is the first flushed cycle, and MD_WAIT runs
    // from the loaded value down to 0 inclusive, hence the -2.
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 2);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 2);

    pipe_state_t state, state_next;
    stage_ctrl_t ctrl;
    logic        busy_c;
    logic        done_c;
    logic        cnt_load;
    logic        cnt_dec;
    logic        cnt_zero;

    md_latency_cnt #(.CNT_W(CNT_W)) u_md_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (md_is_div ? DIV_LOAD : MUL_LOAD),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        ctrl       = ctrl_service(hazard_stall, branch_taken);
        busy_c     = 1'b0;
        done_c     = 1'b0;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;
        case (state)
            RUN: begin
                if (md_req) begin
                    ctrl       = CTRL_MD_HOLD;
                    busy_c     = 1'b1;
                    cnt_load   = 1'b1;
                    state_next = MD_WAIT;
                end
            end
            MD_WAIT: begin
                ctrl   = CTRL_MD_HOLD;
                busy_c = 1'b1;
                if (cnt_zero) begin
                    state_next = MD_DONE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            MD_DONE: begin
                // md_req still describes the completing instruction here.
                done_c     = 1'b1;
                state_next = RUN;
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    // Outputs are forced low for the whole time rst is high.
    assign pc_en         = ctrl.pc_en         & ~rst;
    assign if_id_en      = ctrl.if_id_en      & ~rst;
    assign if_id_flush   = ctrl.if_id_flush   & ~rst;
    assign id_exe_en     = ctrl.id_exe_en     & ~rst;
    assign id_exe_flush  = ctrl.id_exe_flush  & ~rst;
    assign exe_mem_flush = ctrl.exe_mem_flush & ~rst;
    assign md_busy       = busy_c             & ~rst;
    assign md_done       = done_c             & ~rst;

`ifdef PIPE_CTRL_PERF_EN
    // id_exe_flush is only ever driven by an applied hazard stall, so it
    // doubles as the "stall took effect" qualifier.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_haz_cnt   <= '0;
            perf_md_cnt    <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (id_exe_flush && (perf_haz_cnt != '1)) begin
                perf_haz_cnt <= perf_haz_cnt + 32'd1;
            end
            if (md_busy && (perf_md_cnt != '1)) begin
                perf_md_cnt <= perf_md_cnt + 32'd1;
            end
            if (if_id_flush && (perf_flush_cnt != '1)) begin
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - directed self-checking bench for pipe_ctrl

module tb_pipe_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic hazard_stall = 1'b0;
    logic branch_taken = 1'b0;
    logic md_req = 1'b0;
    logic md_is_div = 1'b0;
    logic pc_en, if_id_en, if_id_flush, id_exe_en, id_exe_flush;
    logic exe_mem_flush, md_busy, md_done;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perf_haz_cnt, perf_md_cnt, perf_flush_cnt;
`endif

    int checks = 0;
    int errors = 0;

    // {pc_en, if_id_en, if_id_flush, id_exe_en, id_exe_flush, exe_mem_flush, md_busy, md_done}
    localparam logic [7:0] EXP_OFF  = 8'b0000_0000;
    localparam logic [7:0] EXP_RUN  = 8'b1101_0000;
    localparam logic [7:0] EXP_HAZ  = 8'b0001_1000;
    localparam logic [7:0] EXP_BR   = 8'b1111_0000;
    localparam logic [7:0] EXP_MD   = 8'b0000_0110;
    localparam logic [7:0] EXP_DONE = 8'b1101_0001;
    localparam logic [7:0] EXP_DHAZ = 8'b0001_1001;

    logic [7:0] obs;
    assign obs = {pc_en, if_id_en, if_id_flush, id_exe_en, id_exe_flush,
                  exe_mem_flush, md_busy, md_done};

    pipe_ctrl #(.MUL_CYCLES(4), .DIV_CYCLES(32), .CNT_W(6)) dut (
        .clk           (clk),
        .rst           (rst),
        .hazard_stall  (hazard_stall),
        .branch_taken  (branch_taken),
        .md_req        (md_req),
        .md_is_div     (md_is_div),
        .pc_en         (pc_en),
        .if_id_en      (if_id_en),
        .if_id_flush   (if_id_flush),
        .id_exe_en     (id_exe_en),
        .id_exe_flush  (id_exe_flush),
        .exe_mem_flush (exe_mem_flush),
        .md_busy       (md_busy),
        .md_done       (md_done)
`ifdef PIPE_CTRL_PERF_EN
        ,
        .perf_haz_cnt  (perf_haz_cnt),
        .perf_md_cnt   (perf_md_cnt),
        .perf_flush_cnt(perf_flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Inputs change at the falling edge; Mealy outputs are sampled 1ns later.
    task automatic drive(input logic h, input logic b, input logic m, input logic d);
        @(negedge clk);
        hazard_stall = h;
        branch_taken = b;
        md_req       = m;
        md_is_div    = d;
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 1'b1);
        checks++;
        if (obs !== EXP_OFF) begin
            errors++;
            $display("FAIL reset_outputs got=%b exp=%b", obs, EXP_OFF);
        end
        @(negedge clk);
        rst = 1'b0;
        hazard_stall = 1'b0; branch_taken = 1'b0; md_req = 1'b0; md_is_div = 1'b0;
        #1;
        checks++;
        if (obs !== EXP_RUN) begin
            errors++;
            $display("FAIL reset_release got=%b exp=%b", obs, EXP_RUN);
        end
    endtask

    task automatic test_hazard;
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        checks++;
        if (obs !== EXP_HAZ) begin
            errors++;
            $display("FAIL hazard_with_branch got=%b exp=%b", obs, EXP_HAZ);
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (obs !== EXP_HAZ) begin
            errors++;
            $display("FAIL hazard_second got=%b exp=%b", obs, EXP_HAZ);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (obs !== EXP_RUN) begin
            errors++;
            $display("FAIL hazard_release got=%b exp=%b", obs, EXP_RUN);
        end
    endtask

    task automatic test_branch;
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (obs !== EXP_BR) begin
            errors++;
            $display("FAIL branch_flush got=%b exp=%b", obs, EXP_BR);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (obs !== EXP_RUN) begin
            errors++;
            $display("FAIL branch_one_cycle got=%b exp=%b", obs, EXP_RUN);
        end
    endtask

    // md_req held high and hazard/branch toggled during the wait: all masked.
    task automatic test_mul;
        for (int i = 0; i < 4; i++) begin
            drive(i[0], ~i[0], 1'b1, 1'b0);
            checks++;
            if (obs !== EXP_MD) begin
                errors++;
                $display("FAIL mul_hold cyc=%0d got=%b exp=%b", i, obs, EXP_MD);
            end
        end
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (obs !== EXP_DONE) begin
            errors++;
            $display("FAIL mul_done got=%b exp=%b", obs, EXP_DONE);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (obs !== EXP_RUN) begin
            errors++;
            $display("FAIL mul_after got=%b exp=%b", obs, EXP_RUN);
        end
    endtask

    task automatic test_done_hazard;
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 1'b1, 1'b0);
        end
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        checks++;
        if (obs !== EXP_DHAZ) begin
            errors++;
            $display("FAIL done_hazard got=%b exp=%b", obs, EXP_DHAZ);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (obs !== EXP_RUN) begin
            errors++;
            $display("FAIL done_hazard_after got=%b exp=%b", obs, EXP_RUN);
        end
    endtask

    task automatic test_div_reset;
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 1'b0, 1'b1, 1'b1);
            checks++;
            if (obs !== EXP_MD) begin
                errors++;
                $display("FAIL div_pre cyc=%0d got=%b exp=%b", i, obs, EXP_MD);
            end
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (obs !== EXP_OFF) begin
            errors++;
            $display("FAIL div_rst_outputs got=%b exp=%b", obs, EXP_OFF);
        end
        @(negedge clk);
        rst = 1'b0;
        md_req = 1'b0; md_is_div = 1'b0;
        #1;
        checks++;
        if (obs !== EXP_RUN) begin
            errors++;
            $display("FAIL div_rst_run got=%b exp=%b", obs, EXP_RUN);
        end
        for (int i = 0; i < 32; i++) begin
            drive(1'b0, 1'b0, 1'b1, 1'b1);
            checks++;
            if (obs !== EXP_MD) begin
                errors++;
                $display("FAIL div_full cyc=%0d got=%b exp=%b", i, obs, EXP_MD);
            end
        end
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        checks++;
        if (obs !== EXP_DONE) begin
            errors++;
            $display("FAIL div_done got=%b exp=%b", obs, EXP_DONE);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (obs !== EXP_RUN) begin
            errors++;
            $display("FAIL div_after got=%b exp=%b", obs, EXP_RUN);
        end
    endtask

    // Second mult requested immediately after MD_DONE starts a fresh sequence.
    task automatic test_back_to_back;
        logic [7:0] exp_seq [0:9];
        exp_seq = '{EXP_MD, EXP_MD, EXP_MD, EXP_MD, EXP_DONE,
                    EXP_MD, EXP_MD, EXP_MD, EXP_MD, EXP_DONE};
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 1'b0, 1'b1, 1'b0);
            checks++;
            if (obs !== exp_seq[i]) begin
                errors++;
                $display("FAIL b2b cyc=%0d got=%b exp=%b", i, obs, exp_seq[i]);
            end
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (obs !== EXP_RUN) begin
            errors++;
            $display("FAIL b2b_after got=%b exp=%b", obs, EXP_RUN);
        end
    endtask

`ifdef PIPE_CTRL_PERF_EN
    task automatic test_perf;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        // MUL with a masked hazard during the wait.
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (perf_md_cnt !== 32'd4) begin
            errors++;
            $display("FAIL perf_md got=%0d exp=4", perf_md_cnt);
        end
        checks++;
        if (perf_haz_cnt !== 32'd3) begin
            errors++;
            $display("FAIL perf_haz got=%0d exp=3", perf_haz_cnt);
        end
        checks++;
        if (perf_flush_cnt !== 32'd1) begin
            errors++;
            $display("FAIL perf_flush got=%0d exp=1", perf_flush_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_hazard();
        test_branch();
        test_mul();
        test_done_hazard();
        test_div_reset();
        test_back_to_back();
`ifdef PIPE_CTRL_PERF_EN
        test_perf();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
